// File: rtl/fetch_exec_sequencer_if.sv
// Signal bundle between the nic8 fetch/execute sequencer (slave) and the datapath/debug host (master).
// Counter widths CW/IW must match the sequencer instance they connect to.
interface fetch_exec_sequencer_if #(
    parameter int CW = 16,
    parameter int IW = 16
);
    // Timing of the signals in this bundle:
    // - The requests (haltReq, runReq) are levels, sampled on the rising clock edge.
    // - stepReq acts on its rising edge.
    // - The strobes (clrPC, loadIR, incPC, execEn) are qualifiers that are valid
    //   for the whole current cycle and act on the next rising edge.
    // - There is no backpressure: the datapath always accepts a strobe in the
    //   cycle it is raised.
    logic [7:0]    ir;
    logic          haltReq;
    logic          runReq;
    logic          stepReq;
    logic          clrPC;
    logic          loadIR;
    logic          incPC;
    logic          execEn;
    logic          halted;
    logic [1:0]    phase;
    logic [CW-1:0] cycleCount;
    logic [IW-1:0] instrCount;

    modport master (
        output ir, haltReq, runReq, stepReq,
        input  clrPC, loadIR, incPC, execEn, halted, phase, cycleCount, instrCount
    );

    modport slave (
        input  ir, haltReq, runReq, stepReq,
        output clrPC, loadIR, incPC, execEn, halted, phase, cycleCount, instrCount
    );
endinterface

// File: rtl/fetch_exec_sequencer.sv
// Two-phase fetch/execute sequencer for the nic8 CPU with halt/run control and debug counters.
// Optional single-step support is compiled in when SEQ_SINGLE_STEP_EN is defined.
module fetch_exec_sequencer #(
    parameter int         RESET_CYCLES = 2,
    parameter logic [2:0] HALT_DEST    = 3'd7,
    parameter int         CW           = 16,
    parameter int         IW           = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_exec_sequencer_if.slave  bus
);
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [RW-1:0] r_rst_cnt;
    logic [CW-1:0] r_cycle_cnt;
    logic [IW-1:0] r_instr_cnt;

    logic w_halt_op;
    logic w_step_pending;
    logic w_clr_pc;
    logic w_load_ir;
    logic w_inc_pc;
    logic w_exec_en;
    logic w_halted;
    logic w_unused;

`ifdef SEQ_SINGLE_STEP_EN
    logic r_step_q;
    logic r_step_latch;
    logic w_step_edge;

    assign w_step_edge    = bus.stepReq & ~r_step_q;
    assign w_step_pending = r_step_latch;
    assign w_unused       = bus.ir[7] ^ bus.ir[3];
`else
    // Set when HALT was entered through the halt opcode; only reset leaves that HALT.
    logic r_halt_op;

    assign w_step_pending = 1'b0;
    assign w_unused       = bus.ir[7] ^ bus.ir[3] ^ bus.stepReq;
`endif

    assign w_halt_op = (bus.ir[6:4] == HALT_DEST);

    always_comb begin
        w_next_state = r_state;
        w_clr_pc     = 1'b0;
        w_load_ir    = 1'b0;
        w_inc_pc     = 1'b0;
        w_exec_en    = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            ST_RESET: begin
                w_clr_pc = 1'b1;
                if (r_rst_cnt == '0) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_load_ir    = 1'b1;
                w_inc_pc     = 1'b1;
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                // A halt opcode retires without touching the datapath.
                w_exec_en = ~w_halt_op;
                w_inc_pc  = (bus.ir[2:0] == 3'b000);
                if (w_halt_op || bus.haltReq || w_step_pending) begin
                    w_next_state = ST_HALT;
                end else begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_HALT: begin
                w_halted = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
                if (bus.runReq || w_step_edge) begin
                    w_next_state = ST_FETCH;
                end
`else
                if (bus.runReq && !r_halt_op) begin
                    w_next_state = ST_FETCH;
                end
`endif
            end
            default: begin
                w_next_state = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RESET;
            r_rst_cnt   <= RW'(RESET_CYCLES - 1);
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_RESET && r_rst_cnt != '0) begin
                r_rst_cnt <= r_rst_cnt - RW'(1);
            end
            if (r_state != ST_HALT) begin
                r_cycle_cnt <= r_cycle_cnt + CW'(1);
            end
            if (r_state == ST_EXEC) begin
                r_instr_cnt <= r_instr_cnt + IW'(1);
            end
        end
    end

`ifdef SEQ_SINGLE_STEP_EN
    // Edges seen outside HALT are dropped; the latch only arms from HALT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_q     <= 1'b0;
            r_step_latch <= 1'b0;
        end else begin
            r_step_q <= bus.stepReq;
            if (r_state == ST_HALT) begin
                if (bus.runReq) begin
                    r_step_latch <= 1'b0;
                end else if (w_step_edge) begin
                    r_step_latch <= 1'b1;
                end
            end else if (r_state == ST_EXEC && w_next_state == ST_HALT) begin
                r_step_latch <= 1'b0;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_halt_op <= 1'b0;
        end else if (r_state == ST_EXEC && w_halt_op) begin
            r_halt_op <= 1'b1;
        end
    end
`endif

    assign bus.clrPC      = w_clr_pc;
    assign bus.loadIR     = w_load_ir;
    assign bus.incPC      = w_inc_pc;
    assign bus.execEn     = w_exec_en;
    assign bus.halted     = w_halted;
    assign bus.phase      = r_state;
    assign bus.cycleCount = r_cycle_cnt;
    assign bus.instrCount = r_instr_cnt;
endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Directed, table-driven bench for fetch_exec_sequencer: each row gives one cycle of inputs and the outputs expected in that cycle.
module tb_fetch_exec_sequencer;
    localparam int CW = 16;
    localparam int IW = 16;

    logic clk;
    logic reset;

    fetch_exec_sequencer_if #(.CW(CW), .IW(IW)) bus ();

    fetch_exec_sequencer #(
        .RESET_CYCLES(2),
        .HALT_DEST   (3'd7),
        .CW          (CW),
        .IW          (IW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic          rst;
        logic [7:0]    ir;
        logic          hreq;
        logic          rreq;
        logic          sreq;
        logic          clr;
        logic          ld;
        logic          inc;
        logic          ex;
        logic          hlt;
        logic [1:0]    ph;
        logic [CW-1:0] cc;
        logic [IW-1:0] ic;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic rst, input logic [7:0] ir, input logic hreq,
                                input logic rreq, input logic sreq, input logic clr, input logic ld,
                                input logic inc, input logic ex, input logic hlt, input int ph,
                                input int cc, input int ic);
        vec_t v;
        v.rst = rst; v.ir = ir; v.hreq = hreq; v.rreq = rreq; v.sreq = sreq;
        v.clr = clr; v.ld = ld; v.inc = inc; v.ex = ex; v.hlt = hlt;
        v.ph = ph[1:0]; v.cc = cc[CW-1:0]; v.ic = ic[IW-1:0];
        return v;
    endfunction

    task automatic run_row(input vec_t v, input string name, input int idx);
        logic [38:0] act;
        logic [38:0] exp;
        reset       = v.rst;
        bus.ir      = v.ir;
        bus.haltReq = v.hreq;
        bus.runReq  = v.rreq;
        bus.stepReq = v.sreq;
        @(negedge clk);
        act = {bus.clrPC, bus.loadIR, bus.incPC, bus.execEn, bus.halted, bus.phase,
               bus.cycleCount, bus.instrCount};
        exp = {v.clr, v.ld, v.inc, v.ex, v.hlt, v.ph, v.cc, v.ic};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got clr=%b ld=%b inc=%b ex=%b hlt=%b ph=%0d cc=%0d ic=%0d, required clr=%b ld=%b inc=%b ex=%b hlt=%b ph=%0d cc=%0d ic=%0d",
                     name, idx, bus.clrPC, bus.loadIR, bus.incPC, bus.execEn, bus.halted,
                     bus.phase, bus.cycleCount, bus.instrCount,
                     v.clr, v.ld, v.inc, v.ex, v.hlt, v.ph, v.cc, v.ic);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        bus.ir      = 8'h21;
        bus.haltReq = 1'b0;
        bus.runReq  = 1'b0;
        bus.stepReq = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset release, then free-run with ir=0x21 (register source, one PC bump per instruction).
        tbl.push_back(mk(0, 8'h21, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h21, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        for (int p = 0; p < 5; p++) begin
            tbl.push_back(mk(0, 8'h21, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2 + 2 * p, p));
            tbl.push_back(mk(0, 8'h21, 0, 0, 0, 0, 0, 0, 1, 0, 2, 3 + 2 * p, p));
        end
        // ROM-immediate source: incPC in FETCH and EXEC.
        tbl.push_back(mk(0, 8'h20, 0, 0, 0, 0, 1, 1, 0, 0, 1, 12, 5));
        tbl.push_back(mk(0, 8'h20, 0, 0, 0, 0, 0, 1, 1, 0, 2, 13, 5));
        tbl.push_back(mk(0, 8'h20, 0, 0, 0, 0, 1, 1, 0, 0, 1, 14, 6));
        // haltReq in EXEC -> HALT; counters frozen there.
        tbl.push_back(mk(0, 8'h20, 1, 0, 0, 0, 0, 1, 1, 0, 2, 15, 6));
        tbl.push_back(mk(0, 8'h20, 1, 0, 0, 0, 0, 0, 0, 1, 3, 16, 7));
        tbl.push_back(mk(0, 8'h21, 1, 0, 0, 0, 0, 0, 0, 1, 3, 16, 7));
        // haltReq + runReq: HALT -> FETCH -> EXEC -> HALT loop.
        tbl.push_back(mk(0, 8'h21, 1, 1, 0, 0, 0, 0, 0, 1, 3, 16, 7));
        tbl.push_back(mk(0, 8'h21, 1, 1, 0, 0, 1, 1, 0, 0, 1, 16, 7));
        tbl.push_back(mk(0, 8'h21, 1, 1, 0, 0, 0, 0, 1, 0, 2, 17, 7));
        tbl.push_back(mk(0, 8'h21, 0, 0, 0, 0, 0, 0, 0, 1, 3, 18, 8));
        tbl.push_back(mk(0, 8'h21, 0, 1, 0, 0, 0, 0, 0, 1, 3, 18, 8));
        // haltReq raised during FETCH: the instruction completes, then HALT.
        tbl.push_back(mk(0, 8'h21, 1, 0, 0, 0, 1, 1, 0, 0, 1, 18, 8));
        tbl.push_back(mk(0, 8'h21, 1, 0, 0, 0, 0, 0, 1, 0, 2, 19, 8));
        tbl.push_back(mk(0, 8'h21, 0, 1, 0, 0, 0, 0, 0, 1, 3, 20, 9));
        // Halt opcode (dest=7): execEn suppressed, still retires.
        tbl.push_back(mk(0, 8'h21, 0, 0, 0, 0, 1, 1, 0, 0, 1, 20, 9));
        tbl.push_back(mk(0, 8'h71, 0, 0, 0, 0, 0, 0, 0, 0, 2, 21, 9));
        tbl.push_back(mk(0, 8'h21, 0, 0, 0, 0, 0, 0, 0, 1, 3, 22, 10));
        for (int k = 0; k < 20; k++) begin
            tbl.push_back(mk(0, 8'h21, 0, 0, 0, 0, 0, 0, 0, 1, 3, 22, 10));
        end

        apply_reset();
        for (int k = 0; k < tbl.size(); k++) begin
            run_row(tbl[k], "table", k);
        end

`ifdef SEQ_SINGLE_STEP_EN
        for (int k = 0; k < 3; k++) begin
            run_row(mk(0, 8'h21, 0, 0, 1, 0, 0, 0, 0, 1, 3, 22 + 2 * k, 10 + k), "step_halt", k);
            run_row(mk(0, 8'h21, 0, 0, 0, 0, 1, 1, 0, 0, 1, 22 + 2 * k, 10 + k), "step_fetch", k);
            run_row(mk(0, 8'h21, 0, 0, 0, 0, 0, 0, 1, 0, 2, 23 + 2 * k, 10 + k), "step_exec", k);
        end
        run_row(mk(0, 8'h21, 0, 1, 1, 0, 0, 0, 0, 1, 3, 28, 13), "run_wins", 0);
        run_row(mk(0, 8'h21, 0, 0, 0, 0, 1, 1, 0, 0, 1, 28, 13), "run_wins", 1);
        run_row(mk(0, 8'h21, 0, 0, 0, 0, 0, 0, 1, 0, 2, 29, 13), "run_wins", 2);
        run_row(mk(0, 8'h21, 0, 0, 0, 0, 1, 1, 0, 0, 1, 30, 14), "run_wins", 3);
`else
        // Halt-opcode HALT ignores runReq and stepReq.
        run_row(mk(0, 8'h21, 0, 1, 0, 0, 0, 0, 0, 1, 3, 22, 10), "haltop_sticky", 0);
        run_row(mk(0, 8'h21, 0, 1, 1, 0, 0, 0, 0, 1, 3, 22, 10), "haltop_sticky", 1);
        run_row(mk(0, 8'h21, 0, 0, 0, 0, 0, 0, 0, 1, 3, 22, 10), "haltop_sticky", 2);
        run_row(mk(0, 8'h21, 0, 1, 1, 0, 0, 0, 0, 1, 3, 22, 10), "haltop_sticky", 3);
        run_row(mk(0, 8'h21, 0, 1, 0, 0, 0, 0, 0, 1, 3, 22, 10), "haltop_sticky", 4);
`endif

        // Reset asserted mid-EXEC with nonzero counters.
        apply_reset();
        run_row(mk(0, 8'h21, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "mid_reset", 0);
        run_row(mk(0, 8'h21, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0), "mid_reset", 1);
        run_row(mk(0, 8'h21, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2, 0), "mid_reset", 2);
        run_row(mk(0, 8'h21, 0, 0, 0, 0, 0, 0, 1, 0, 2, 3, 0), "mid_reset", 3);
        run_row(mk(0, 8'h21, 0, 0, 0, 0, 1, 1, 0, 0, 1, 4, 1), "mid_reset", 4);
        run_row(mk(1, 8'h21, 0, 0, 0, 0, 0, 0, 1, 0, 2, 5, 1), "mid_reset", 5);
        run_row(mk(0, 8'h21, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "mid_reset", 6);
        run_row(mk(0, 8'h21, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0), "mid_reset", 7);
        run_row(mk(0, 8'h21, 0, 0, 0, 0, 1, 1, 0, 0, 1, 2, 0), "mid_reset", 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
